// File: rtl/ccu_cmd_queue_pkg.sv
// ccu_cmd_queue_pkg: shared definitions for the CCU command path.
// Holds the command width, the NOP filler value, a few CCU opcode
// constants and the state encoding used by the command queue FSM.
package ccu_cmd_queue_pkg;

  localparam int CCU_CMD_W      = 8;
  localparam int CCU_CMDQ_DEPTH = 16;

  localparam logic [CCU_CMD_W-1:0] CCU_NOP_CMD = 8'd0;

  // CCU opcodes, listed here so host-side code and the queue agree on them
  localparam logic [CCU_CMD_W-1:0] CCU_OP_NOP   = 8'h00;
  localparam logic [CCU_CMD_W-1:0] CCU_OP_CLEAR = 8'h01;
  localparam logic [CCU_CMD_W-1:0] CCU_OP_LINE  = 8'h02;
  localparam logic [CCU_CMD_W-1:0] CCU_OP_FILL  = 8'h03;
  localparam logic [CCU_CMD_W-1:0] CCU_OP_BLIT  = 8'h04;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } cmdq_state_e;

endpackage

// File: rtl/ccu_cmd_queue_fifo.sv
// ccu_cmd_queue_fifo: circular command storage for ccu_cmd_queue.
// Pointers carry an extra wrap bit so full and empty are told apart without
// a separate counter; level is the exact pointer difference across wraps.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clr             discard everything (pointers back to zero)
//   wr_en, wr_data  push a byte (ignored when full or clearing)
//   rd_en, rd_data  pop the head; rd_data shows the head combinationally
//   full, fifo_empty, level   occupancy status
module ccu_cmd_queue_fifo #(
  parameter int DEPTH = 16,
  parameter int CMD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [CMD_W-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [CMD_W-1:0]         rd_data,
  output logic                     full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Full when the index bits match but the wrap bits differ
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign level      = wr_ptr - rd_ptr;
  assign rd_data    = mem[rd_ptr[AW-1:0]];

  assign do_wr = wr_en && !full && !clr;
  assign do_rd = rd_en && !fifo_empty && !clr;

  // Pointer update; clear wins over any push or pop in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array has no reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ccu_cmd_queue.sv
// ccu_cmd_queue: command buffer in front of the CCU.
// Queues host command bytes and presents at most one per clock on a
// registered cmd output; drives NOP_CMD with cmd_valid=0 when idle.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   wr_data/wr_valid/wr_ready   host write handshake
//   flush                 drop every queued and pending command
//   ccu_ready             CCU takes cmd on this edge when cmd_valid
//   cmd, cmd_valid        registered command to the CCU
//   level                 number of bytes still in the queue storage
//   empty                 nothing stored and nothing pending at the CCU
//   overrun_cnt           only with CCU_CMDQ_OVERRUN_CNT_EN: saturating count
//                         of cycles with wr_valid while wr_ready is low
module ccu_cmd_queue
  import ccu_cmd_queue_pkg::*;
#(
  parameter int               DEPTH   = CCU_CMDQ_DEPTH,
  parameter int               CMD_W   = CCU_CMD_W,
  parameter logic [CMD_W-1:0] NOP_CMD = CCU_NOP_CMD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CMD_W-1:0]       wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   flush,
  input  logic                   ccu_ready,
  output logic [CMD_W-1:0]       cmd,
  output logic                   cmd_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty
`ifdef CCU_CMDQ_OVERRUN_CNT_EN
  ,
  output logic [15:0]            overrun_cnt
`endif
);

  cmdq_state_e      state;
  cmdq_state_e      next_state;
  logic [CMD_W-1:0] cmd_q;
  logic [CMD_W-1:0] cmd_d;
  logic             pop;
  logic             full;
  logic             fifo_empty;
  logic [CMD_W-1:0] head;

  ccu_cmd_queue_fifo #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (flush),
    .wr_en      (wr_valid),
    .wr_data    (wr_data),
    .rd_en      (pop),
    .rd_data    (head),
    .full       (full),
    .fifo_empty (fifo_empty),
    .level      (level)
  );

  // wr_ready comes only from the stored pointers, so a pop on the same edge
  // never lets a write through at full
  assign wr_ready  = !full;
  assign cmd       = cmd_q;
  assign cmd_valid = (state != IDLE);
  assign empty     = fifo_empty && (state == IDLE);

  // Next-state and output-register load; the output register is refilled
  // whenever it is empty or the CCU takes its current command
  always_comb begin
    next_state = state;
    cmd_d      = cmd_q;
    pop        = 1'b0;
    if (flush) begin
      next_state = IDLE;
      cmd_d      = NOP_CMD;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            cmd_d      = head;
            next_state = ISSUE;
          end
        end
        ISSUE, STALL: begin
          if (ccu_ready) begin
            if (!fifo_empty) begin
              pop        = 1'b1;
              cmd_d      = head;
              next_state = ISSUE;
            end else begin
              cmd_d      = NOP_CMD;
              next_state = IDLE;
            end
          end else begin
            next_state = STALL;
          end
        end
        default: begin
          next_state = IDLE;
          cmd_d      = NOP_CMD;
        end
      endcase
    end
  end

  // State and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd_q <= NOP_CMD;
    end else begin
      state <= next_state;
      cmd_q <= cmd_d;
    end
  end

`ifdef CCU_CMDQ_OVERRUN_CNT_EN
  // Counts rejected host writes; sticks at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      overrun_cnt <= 16'd0;
    end else if (wr_valid && !wr_ready && (overrun_cnt != 16'hFFFF)) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ccu_cmd_queue.sv
// tb_ccu_cmd_queue: self-checking bench for ccu_cmd_queue.
// A transaction-level model tracks how many bytes sit in storage and whether
// one is waiting at the CCU; accepted bytes go into a scoreboard queue and a
// separate monitor pops it on every CCU handshake.
// Optional feature macro: CCU_CMDQ_OVERRUN_CNT_EN.
module tb_ccu_cmd_queue;

  localparam int DEPTH = 16;
  localparam int CMD_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CMD_W-1:0] wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             flush = 1'b0;
  logic             ccu_ready = 1'b0;
  logic             wr_ready;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic [LW-1:0]    level;
  logic             empty;
`ifdef CCU_CMDQ_OVERRUN_CNT_EN
  logic [15:0]      overrun_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [CMD_W-1:0] sb[$];
  int               stored = 0;
  bit               pending = 1'b0;
  int               ov_model = 0;

  ccu_cmd_queue #(
    .DEPTH   (DEPTH),
    .CMD_W   (CMD_W),
    .NOP_CMD (8'd0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .flush       (flush),
    .ccu_ready   (ccu_ready),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .level       (level),
    .empty       (empty)
`ifdef CCU_CMDQ_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: one step per edge, using the inputs held over the cycle
  always @(posedge clk) begin
    bit acc;
    if (!rst_n || flush) begin
      stored   = 0;
      pending  = 1'b0;
      ov_model = 0;
      sb.delete();
    end else begin
      acc = wr_valid && (stored < DEPTH);
      if (wr_valid && !acc && ov_model != 65535) ov_model++;
      if (!pending || ccu_ready) begin
        if (stored > 0) begin
          stored--;
          pending = 1'b1;
        end else begin
          pending = 1'b0;
        end
      end
      if (acc) begin
        stored++;
        sb.push_back(wr_data);
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every CCU handshake must deliver the oldest accepted byte
  always @(negedge clk) begin
    if (rst_n && cmd_valid && ccu_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL ccu_cmd: got %0d expected no command", cmd);
      end else begin
        logic [CMD_W-1:0] exp;
        exp = sb.pop_front();
        if (cmd !== exp) begin
          errors++;
          $display("[TB] FAIL ccu_cmd: got %0d expected %0d", cmd, exp);
        end
      end
    end
  end

  task automatic checkModel();
    checkOutput("wr_ready", int'(wr_ready), int'(stored < DEPTH));
    checkOutput("level", int'(level), stored);
    checkOutput("cmd_valid", int'(cmd_valid), int'(pending));
    checkOutput("empty", int'(empty), int'(stored == 0 && !pending));
    if (!pending) checkOutput("idle_cmd", int'(cmd), 0);
`ifdef CCU_CMDQ_OVERRUN_CNT_EN
    checkOutput("overrun_cnt", int'(overrun_cnt), ov_model);
`endif
  endtask

  task automatic applyStimulus(input bit wv, input logic [CMD_W-1:0] wd,
                               input bit fl, input bit cr);
    wr_valid  = wv;
    wr_data   = wd;
    flush     = fl;
    ccu_ready = cr;
    @(posedge clk);
    #1;
    checkModel();
  endtask

  initial begin
    $display("[TB] start");

    // Reset held for two clocks
    rst_n = 1'b0;
    applyStimulus(0, 8'd0, 0, 0);
    applyStimulus(0, 8'd0, 0, 0);
    checkOutput("rst_cmd", int'(cmd), 0);
    checkOutput("rst_cmd_valid", int'(cmd_valid), 0);
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_wr_ready", int'(wr_ready), 1);
    checkOutput("rst_empty", int'(empty), 1);
    rst_n = 1'b1;

    // Stream of even bytes with the CCU always ready
    for (int i = 1; i <= 10; i++) applyStimulus(1, 8'(2 * i), 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'd0, 0, 1);
    checkOutput("stream_end_valid", int'(cmd_valid), 0);
    checkOutput("stream_end_cmd", int'(cmd), 0);

    // Stall: 76 must sit stable at the CCU until released
    applyStimulus(1, 8'd76, 0, 0);
    applyStimulus(1, 8'd2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 8'd0, 0, 0);
      checkOutput("stall_cmd", int'(cmd), 76);
      checkOutput("stall_valid", int'(cmd_valid), 1);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'd0, 0, 1);

    // Fill to full and beyond, then cycle the pointers around several times
    for (int i = 0; i < 20; i++) applyStimulus(1, 8'($urandom), 0, 0);
    checkOutput("full_wr_ready", int'(wr_ready), 0);
    checkOutput("full_level", int'(level), DEPTH);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) applyStimulus(0, 8'd0, 0, 1);
      for (int i = 0; i < 18; i++) applyStimulus(1, 8'($urandom), 0, 0);
    end
    for (int i = 0; i < 20; i++) applyStimulus(0, 8'd0, 0, 1);

    // Flush with a concurrent write; 0xAB must never reach the CCU
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'(100 + i), 0, 0);
    applyStimulus(1, 8'hAB, 1, 0);
    checkOutput("flush_level", int'(level), 0);
    checkOutput("flush_valid", int'(cmd_valid), 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'd0, 0, 1);

`ifdef CCU_CMDQ_OVERRUN_CNT_EN
    // Four rejected writes while full, then flush clears the count
    for (int i = 0; i < 17; i++) applyStimulus(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'($urandom), 0, 0);
    checkOutput("overrun_four", int'(overrun_cnt), 4);
    applyStimulus(0, 8'd0, 1, 0);
    checkOutput("overrun_flush", int'(overrun_cnt), 0);
`endif

    // Random traffic with rare flushes and one reset in mid-burst
    for (int i = 0; i < 400; i++) begin
      if (i == 200) rst_n = 1'b0;
      if (i == 201) rst_n = 1'b1;
      applyStimulus($urandom_range(0, 99) < 60, 8'($urandom),
                    $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 50);
    end

    // Drain everything still queued
    for (int i = 0; i < 40; i++) applyStimulus(0, 8'd0, 0, 1);
    checkOutput("drain_leftover", sb.size(), 0);
    checkOutput("drain_empty", int'(empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
